// File: rtl/exec_muldiv_shared.sv
// exec_muldiv_shared: shared MULT/MULTU/DIV/DIVU engine serving issue lanes highest index first.
// Pipelined multiplier plus restoring radix-2 divider; per-lane HI/LO held until the next group.
module exec_muldiv_shared #(
    parameter int LANES   = 2,
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 3
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     start,
    input  logic [LANES-1:0]         valid,
    input  logic [2*LANES-1:0]       op,
    input  logic [DATA_W*LANES-1:0]  srca,
    input  logic [DATA_W*LANES-1:0]  srcb,
    output logic [DATA_W*LANES-1:0]  hi,
    output logic [DATA_W*LANES-1:0]  lo,
    output logic [LANES-1:0]         lane_done,
    output logic                     finish,
    output logic                     busy
);
    localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
    localparam int CW = $clog2(DATA_W + 2);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t              r_state, w_state_nx;
    logic [CW-1:0]       r_cnt, w_cnt_nx;
    logic [LW-1:0]       r_lane, w_lane_nx;
    logic [LANES-1:0]    r_pend, w_pend_nx, r_done, w_done_nx;
    logic [1:0]          r_op [LANES];
    logic [DATA_W-1:0]   r_a [LANES], r_b [LANES], r_hi [LANES], r_lo [LANES];
    logic [DATA_W-1:0]   r_rem, r_quo;

    function automatic logic [LW-1:0] f_top(input logic [LANES-1:0] m);
        f_top = '0;
        for (int i = 0; i < LANES; i++)
            if (m[i]) f_top = LW'(i);
    endfunction

    logic                w_accept, w_fin_lane, w_wr, w_sgn, w_a_neg, w_b_neg, w_ge;
    logic [LW-1:0]       w_top_v, w_top_rest;
    logic [LANES-1:0]    w_rest;
    logic [1:0]          w_op;
    logic [DATA_W-1:0]   w_a, w_b, w_a_mag, w_b_mag, w_rem_in, w_quo_in;
    logic [DATA_W-1:0]   w_rem_step, w_quo_step, w_q_fix, w_r_fix, w_wr_hi, w_wr_lo;
    logic [DATA_W:0]     w_sh, w_diff;
    logic [2*DATA_W-1:0] w_ea, w_eb, w_prod, w_mres;

    assign w_op    = r_op[r_lane];
    assign w_a     = r_a[r_lane];
    assign w_b     = r_b[r_lane];
    assign w_sgn   = ~w_op[0];
    assign w_a_neg = w_sgn & w_a[DATA_W-1];
    assign w_b_neg = w_sgn & w_b[DATA_W-1];

    // Sign/zero extension to 2*DATA_W lets one unsigned multiply serve MULT and MULTU.
    assign w_ea   = {{DATA_W{w_a_neg}}, w_a};
    assign w_eb   = {{DATA_W{w_b_neg}}, w_b};
    assign w_prod = w_ea * w_eb;

    generate
        if (MUL_LAT == 1) begin : g_mul_comb
            assign w_mres = w_prod;
        end else begin : g_mul_pipe
            logic [2*DATA_W-1:0] r_mp [MUL_LAT-1];
            always_ff @(posedge clk) begin
                r_mp[0] <= w_prod;
                for (int i = 1; i < MUL_LAT - 1; i++)
                    r_mp[i] <= r_mp[i-1];
            end
            assign w_mres = r_mp[MUL_LAT-2];
        end
    endgenerate

    assign w_a_mag    = w_a_neg ? -w_a : w_a;
    assign w_b_mag    = w_b_neg ? -w_b : w_b;
    assign w_rem_in   = (r_cnt == '0) ? '0 : r_rem;
    assign w_quo_in   = (r_cnt == '0) ? w_a_mag : r_quo;
    assign w_sh       = {w_rem_in, w_quo_in[DATA_W-1]};
    assign w_diff     = w_sh - {1'b0, w_b_mag};
    assign w_ge       = ~w_diff[DATA_W];
    assign w_rem_step = w_ge ? w_diff[DATA_W-1:0] : w_sh[DATA_W-1:0];
    assign w_quo_step = {w_quo_in[DATA_W-2:0], w_ge};

    // Most-negative / -1 needs no special case: the magnitude quotient negates back to itself.
    assign w_q_fix = (w_a_neg ^ w_b_neg) ? -r_quo : r_quo;
    assign w_r_fix = w_a_neg ? -r_rem : r_rem;

    assign w_wr_hi = (r_state == S_MUL) ? w_mres[2*DATA_W-1:DATA_W] : (w_b == '0) ? w_a : w_r_fix;
    assign w_wr_lo = (r_state == S_MUL) ? w_mres[DATA_W-1:0] : (w_b == '0) ? '1 : w_q_fix;

    assign w_accept   = start & ~flush & (r_state == S_IDLE || r_state == S_DONE);
    assign w_fin_lane = (r_state == S_MUL && r_cnt == CW'(MUL_LAT - 1)) ||
                        (r_state == S_DIV && r_cnt == CW'(DATA_W));
    assign w_rest     = r_pend & ~(LANES'(1) << r_lane);
    assign w_top_v    = f_top(valid);
    assign w_top_rest = f_top(w_rest);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_lane_nx  = r_lane;
        w_pend_nx  = r_pend;
        w_done_nx  = r_done;
        w_wr       = 1'b0;
        if (flush) begin
            w_state_nx = S_IDLE;
            w_pend_nx  = '0;
            w_done_nx  = '0;
        end else if (w_accept) begin
            w_pend_nx  = valid;
            w_done_nx  = '0;
            w_lane_nx  = w_top_v;
            w_cnt_nx   = '0;
            w_state_nx = ~|valid ? S_DONE : op[{w_top_v, 1'b1}] ? S_DIV : S_MUL;
        end else if (busy) begin
            w_cnt_nx = r_cnt + CW'(1);
            if (w_fin_lane) begin
                w_wr       = 1'b1;
                w_pend_nx  = w_rest;
                w_done_nx  = r_done | (LANES'(1) << r_lane);
                w_lane_nx  = w_top_rest;
                w_cnt_nx   = '0;
                w_state_nx = ~|w_rest ? S_DONE : r_op[w_top_rest][1] ? S_DIV : S_MUL;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_lane  <= '0;
            r_pend  <= '0;
            r_done  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_lane  <= w_lane_nx;
            r_pend  <= w_pend_nx;
            r_done  <= w_done_nx;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < LANES; i++) begin
                r_hi[i] <= '0;
                r_lo[i] <= '0;
            end
        end else if (w_wr) begin
            r_hi[r_lane] <= w_wr_hi;
            r_lo[r_lane] <= w_wr_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < LANES; i++) begin
                r_op[i] <= op[2*i +: 2];
                r_a[i]  <= srca[DATA_W*i +: DATA_W];
                r_b[i]  <= srcb[DATA_W*i +: DATA_W];
            end
        end
        if (r_state == S_DIV && r_cnt != CW'(DATA_W)) begin
            r_rem <= w_rem_step;
            r_quo <= w_quo_step;
        end
    end

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_out
            assign hi[DATA_W*g +: DATA_W] = r_hi[g];
            assign lo[DATA_W*g +: DATA_W] = r_lo[g];
        end
    endgenerate

    assign lane_done = r_done;
    assign finish    = ~|r_pend;
    assign busy      = (r_state == S_MUL) || (r_state == S_DIV);
endmodule
